// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU, one restoring step per cycle; done at T+XLEN+1 (T+1 for /0 and overflow).
// Holds the pipeline via combinational stall from start until the DONE cycle; Flush aborts from any state.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            Flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q_q, neg_r_q, is_rem_q;

  logic            accept, is_signed, a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0] a_abs, b_abs, spec_res;

  assign accept    = (state_q == S_IDLE) && start && !Flush;
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & rs1[XLEN-1];
  assign b_neg     = is_signed & rs2[XLEN-1];
  assign a_abs     = a_neg ? -rs1 : rs1;
  assign b_abs     = b_neg ? -rs2 : rs2;
  assign div_zero  = (rs2 == '0);
  assign ovf       = is_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign special   = div_zero || ovf;
  assign spec_res  = div_zero ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);

  // Shifted partial remainder needs one extra bit before the trial subtract.
  logic [XLEN:0]   rem_sh;
  logic            ge, last;
  logic [XLEN-1:0] sub, rem_nx, quo_nx, q_fix, r_fix;

  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign ge     = rem_sh >= {1'b0, dvs_q};
  assign sub    = rem_sh[XLEN-1:0] - dvs_q;
  assign rem_nx = ge ? sub : rem_sh[XLEN-1:0];
  assign quo_nx = {quo_q[XLEN-2:0], ge};
  assign last   = (cnt_q == CNT_W'(1));
  assign q_fix  = neg_q_q ? -quo_nx : quo_nx;
  assign r_fix  = neg_r_q ? -rem_nx : rem_nx;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = start;
        if (accept) state_d = special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (Flush) state_d = S_IDLE;
    if (RST)   stall   = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_rem_q <= 1'b0;
      result   <= '0;
    end else if (!Flush) begin
      if (accept) begin
        rem_q    <= '0;
        quo_q    <= a_abs;
        dvs_q    <= b_abs;
        neg_q_q  <= a_neg ^ b_neg;
        neg_r_q  <= a_neg;
        is_rem_q <= op[1];
        cnt_q    <= special ? '0 : CNT_W'(XLEN);
        if (special) result <= spec_res;
      end else if (state_q == S_CALC) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q - CNT_W'(1);
        if (last) result <= is_rem_q ? r_fix : q_fix;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against a plain-arithmetic RV32M reference.
module tb_div_unit;

  logic        CLK = 1'b0;
  logic        RST, start, Flush;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        stall, busy, done;
  logic [31:0] result;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] last_exp = '0;

  div_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .Flush(Flush), .op(op),
    .rs1(rs1), .rs2(rs2), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V semantics: truncating division, /0 and signed overflow defined.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [31:0] uq, ur;
    if (o[0]) begin
      if (b == 0) begin uq = '1; ur = a; end
      else begin uq = a / b; ur = a % b; end
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin sq = -1; sr = sa; end
      else begin sq = sa / sb; sr = sa % sb; end
      uq = sq[31:0];
      ur = sr[31:0];
    end
    return o[1] ? ur : uq;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] exp;
    bit sp;
    int n, st, bz;
    exp = ref_div(o, a, b);
    sp  = (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    #1;
    n = 0; st = 0; bz = 0;
    while (n < 40) begin
      if (stall) st++;
      if (busy) bz++;
      tick();
      n++;
      if (done) break;
    end
    chk({tag, " latency"}, n, sp ? 1 : 33);
    chk({tag, " stall_cycles"}, st, sp ? 1 : 33);
    chk({tag, " busy_cycles"}, bz, sp ? 0 : 32);
    chk({tag, " result"}, result, exp);
    chk({tag, " stall_in_done"}, {31'b0, stall}, 0);
    start = 1'b0;
    tick();
    chk({tag, " done_after"}, {31'b0, done}, 0);
    chk({tag, " busy_after"}, {31'b0, busy}, 0);
    chk({tag, " result_held"}, result, exp);
    last_exp = exp;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit seen;

    RST = 1'b1; start = 1'b1; Flush = 1'b0; op = 2'b01; rs1 = 32'd9; rs2 = 32'd3;
    tick(); tick();
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset result", result, 0);
    chk("reset stall", {31'b0, stall}, 0);
    RST = 1'b0; start = 1'b0;
    tick();

    run_op(2'b01, 32'd100, 32'd7, "divu_100_7");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_op(2'b01, 32'd5, 32'd0, "divu_by0");
    run_op(2'b11, 32'd5, 32'd0, "remu_by0");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd0, "div_by0");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, "rem_by0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu_no_ovf");
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "rem_m7_m2");

    // Flush in the 10th CALC cycle.
    op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    tick();
    repeat (9) tick();
    chk("flush pre busy", {31'b0, busy}, 1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0; start = 1'b0;
    #1;
    chk("flush busy", {31'b0, busy}, 0);
    chk("flush done", {31'b0, done}, 0);
    chk("flush result", result, last_exp);
    chk("flush stall", {31'b0, stall}, 0);
    seen = 1'b0;
    repeat (40) begin tick(); if (done) seen = 1'b1; end
    chk("flush no_done", {31'b0, seen}, 0);
    chk("flush result_kept", result, last_exp);
    run_op(2'b11, 32'd1000, 32'd3, "remu_after_flush");

    // Reset in mid-CALC.
    op = 2'b01; rs1 = 32'd50000; rs2 = 32'd7; start = 1'b1;
    tick();
    repeat (5) tick();
    RST = 1'b1;
    tick();
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst done", {31'b0, done}, 0);
    chk("rst result", result, 0);
    chk("rst stall", {31'b0, stall}, 0);
    RST = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (40) begin tick(); if (done) seen = 1'b1; end
    chk("rst no_done", {31'b0, seen}, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, "divu_after_rst");

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 15);
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(ro, ra, rb, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
